// File: rtl/mips32_mem_pkg.sv
// mips32_mem_pkg: shared constants and state encoding for the memory arbiter
package mips32_mem_pkg;
  localparam int DATA_W = 32;
  localparam logic [1:0] REQ_LOAD  = 2'd0;
  localparam logic [1:0] REQ_DATA  = 2'd1;
  localparam logic [1:0] REQ_FETCH = 2'd2;
  localparam logic [1:0] GNT_NONE  = 2'd3;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/mips32_mem_arbiter_if.sv
// mips32_mem_arbiter_if: requester req/ack bundle (req, we, addr, wdata, ack, rdata, grant_id, busy) plus fixed-latency memory port (mem_en, mem_we, mem_addr, mem_wdata, mem_rdata); slave is the arbiter side
interface mips32_mem_arbiter_if import mips32_mem_pkg::*; #(parameter int ADDR_W = 10) ();
  logic [2:0] req;
  logic [2:0] we;
  logic [3*ADDR_W-1:0] addr;
  logic [3*DATA_W-1:0] wdata;
  logic [2:0] ack;
  logic [DATA_W-1:0] rdata;
  logic [1:0] grant_id;
  logic busy;
  logic mem_en;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport master (
    output req, we, addr, wdata, mem_rdata,
    input ack, rdata, grant_id, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input req, we, addr, wdata, mem_rdata,
    output ack, rdata, grant_id, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips32_mem_prio_pick.sv
// mips32_mem_prio_pick: combinational winner select (req[2:0], starve_hit -> id, vld); loader first, then data unless fetch is starving
module mips32_mem_prio_pick import mips32_mem_pkg::*; (
  input  logic [2:0] req,
  input  logic       starve_hit,
  output logic [1:0] id,
  output logic       vld
);
  always_comb begin
    id = req[REQ_LOAD] ? REQ_LOAD :
         (req[REQ_FETCH] && (starve_hit || !req[REQ_DATA])) ? REQ_FETCH :
         req[REQ_DATA] ? REQ_DATA : GNT_NONE;
    vld = |req;
  end
endmodule

// File: rtl/mips32_mem_arbiter.sv
// mips32_mem_arbiter: one-outstanding arbiter (clk1, rst, bus.slave) sharing a fixed-latency word memory among loader, data and fetch
module mips32_mem_arbiter import mips32_mem_pkg::*; #(
  parameter int ADDR_W     = 10,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic clk1,
  input logic rst,
  mips32_mem_arbiter_if.slave bus
);
  state_t state;
  logic [3:0] lat_cnt;
  logic [3:0] starve_cnt;
  logic [1:0] win;
  logic win_vld;
  logic starve_hit;
  assign starve_hit = starve_cnt == 4'(STARVE_MAX);
  assign bus.busy = state != IDLE;
  mips32_mem_prio_pick u_pick (
    .req(bus.req),
    .starve_hit(starve_hit),
    .id(win),
    .vld(win_vld)
  );
  // mem_en is set on the IDLE->ISSUE edge so it is high for exactly the ISSUE cycle;
  // ack is set on the WAIT->RESP edge so it is high for exactly the RESP cycle
  always_ff @(posedge clk1) begin
    if (rst) begin
      state         <= IDLE;
      bus.ack       <= '0;
      bus.rdata     <= '0;
      bus.grant_id  <= GNT_NONE;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      lat_cnt       <= '0;
      starve_cnt    <= '0;
    end else begin
      bus.ack    <= '0;
      bus.mem_en <= 1'b0;
      case (state)
        IDLE: if (win_vld) begin
          state         <= ISSUE;
          bus.grant_id  <= win;
          bus.mem_en    <= 1'b1;
          bus.mem_we    <= bus.we[win];
          bus.mem_addr  <= bus.addr[win*ADDR_W +: ADDR_W];
          bus.mem_wdata <= bus.wdata[win*DATA_W +: DATA_W];
          starve_cnt    <= (win == REQ_FETCH) ? 4'd0 :
                           (bus.req[REQ_FETCH] && !starve_hit) ? starve_cnt + 4'd1 : starve_cnt;
        end
        ISSUE: begin
          state   <= WAIT;
          lat_cnt <= 4'(MEM_LAT);
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) begin
            state     <= RESP;
            bus.ack   <= 3'b001 << bus.grant_id;
            bus.rdata <= bus.mem_we ? bus.rdata : bus.mem_rdata;
          end
        end
        RESP: begin
          state        <= IDLE;
          bus.grant_id <= GNT_NONE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// tb_mips32_mem_arbiter: scoreboard bench driving two arbiters (MEM_LAT=1/STARVE_MAX=2 and MEM_LAT=3/STARVE_MAX=4)
module tb_mips32_mem_arbiter;
  import mips32_mem_pkg::*;
  typedef struct {logic [1:0] id; logic [31:0] rd; int at;} exp_t;
  typedef struct {int at; int g; logic [1:0] gnt; logic busy; logic en; logic [9:0] ma; logic rdc; logic [31:0] rd;} probe_t;
  logic clk1;
  logic [1:0] rst_s;
  logic [2:0] req_s [2];
  logic [2:0] we_s [2];
  logic [29:0] addr_s [2];
  logic [95:0] wdata_s [2];
  logic [2:0] ack_w [2];
  logic [31:0] rdata_w [2];
  logic [1:0] gnt_w [2];
  logic busy_w [2];
  logic en_w [2];
  logic [9:0] maddr_w [2];
  int pend [2][3];
  exp_t q0[$];
  exp_t q1[$];
  probe_t pq[$];
  int cyc = 0;
  int checks = 0;
  int fails = 0;
  int tmo = 0;
  logic done = 1'b0;

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  always @(posedge clk1) cyc <= cyc + 1;

  function automatic logic [31:0] dflt(input logic [9:0] a);
    return a == 10'd5 ? 32'h1234ABCD : 32'hC0DE0000 | 32'(a);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int L = g == 0 ? 1 : 3;
    localparam int S = g == 0 ? 2 : 4;
    mips32_mem_arbiter_if #(.ADDR_W(10)) bus ();
    logic [31:0] mem [1024];
    logic [1023:0] wr = '0;
    logic [31:0] pd [L];
    logic [L-1:0] pv = '0;
    assign bus.req = req_s[g];
    assign bus.we = we_s[g];
    assign bus.addr = addr_s[g];
    assign bus.wdata = wdata_s[g];
    assign bus.mem_rdata = pv[L-1] ? pd[L-1] : 32'hBAD0BAD0;
    assign ack_w[g] = bus.ack;
    assign rdata_w[g] = bus.rdata;
    assign gnt_w[g] = bus.grant_id;
    assign busy_w[g] = bus.busy;
    assign en_w[g] = bus.mem_en;
    assign maddr_w[g] = bus.mem_addr;
    always @(posedge clk1) begin
      if (bus.mem_en && bus.mem_we) begin
        mem[bus.mem_addr] <= bus.mem_wdata;
        wr[bus.mem_addr] <= 1'b1;
      end
      pd[0] <= wr[bus.mem_addr] ? mem[bus.mem_addr] : dflt(bus.mem_addr);
      pv[0] <= bus.mem_en && !bus.mem_we;
      for (int k = 1; k < L; k++) begin
        pd[k] <= pd[k-1];
        pv[k] <= pv[k-1];
      end
    end
    mips32_mem_arbiter #(.ADDR_W(10), .MEM_LAT(L), .STARVE_MAX(S)) dut (
      .clk1(clk1),
      .rst(rst_s[g]),
      .bus(bus.slave)
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk1) begin
    exp_t e;
    probe_t p;
    for (int g = 0; g < 2; g++) if (ack_w[g] != 3'b000) begin
      chk("ack_onehot", 32'($onehot(ack_w[g])), 32'd1);
      chk("ack_vs_mem_en", 32'(en_w[g]), 32'd0);
      if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0))
        chk("unexpected_ack", 32'(ack_w[g]), 32'd0);
      else begin
        if (g == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk("ack_id", 32'(ack_w[g]), 32'(3'b001 << e.id));
        chk("ack_rdata", rdata_w[g], e.rd);
        if (e.at >= 0) chk("ack_cycle", 32'(cyc), 32'(e.at));
      end
    end
    while (pq.size() > 0 && pq[0].at <= cyc) begin
      p = pq.pop_front();
      chk("probe_cycle", 32'(cyc), 32'(p.at));
      chk("grant_id", 32'(gnt_w[p.g]), 32'(p.gnt));
      chk("busy", 32'(busy_w[p.g]), 32'(p.busy));
      chk("mem_en", 32'(en_w[p.g]), 32'(p.en));
      if (p.en) chk("mem_addr", 32'(maddr_w[p.g]), 32'(p.ma));
      if (p.rdc) chk("rdata_hold", rdata_w[p.g], p.rd);
    end
    if (done) begin
      chk("q0_left", 32'(q0.size()), 32'd0);
      chk("q1_left", 32'(q1.size()), 32'd0);
      chk("probes_left", 32'(pq.size()), 32'd0);
      chk("timeouts", 32'(tmo), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
    end else if (cyc > 5000) begin
      checks++;
      fails++;
      $display("FAIL watchdog cyc=%0d actual=running required=done", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
    end
  end

  task automatic set_rq(input int g, input int i, input logic w, input logic [9:0] a, input logic [31:0] d, input int n);
    we_s[g][i] = w;
    addr_s[g][i*10 +: 10] = a;
    wdata_s[g][i*32 +: 32] = d;
    pend[g][i] = n;
  endtask

  task automatic ex(input int g, input logic [1:0] id, input logic [31:0] d, input int at);
    exp_t e;
    e = '{id, d, at};
    if (g == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic pr(input int g, input int dt, input logic [1:0] gnt, input logic b, input logic en,
                    input logic [9:0] ma, input logic rdc, input logic [31:0] rd);
    probe_t p;
    p = '{cyc + dt, g, gnt, b, en, ma, rdc, rd};
    pq.push_back(p);
  endtask

  task automatic run(input int g);
    int n = 0;
    bit ok = 1'b0;
    for (int i = 0; i < 3; i++) if (pend[g][i] > 0) req_s[g][i] = 1'b1;
    while (!ok && n < 400) begin
      @(negedge clk1);
      n++;
      for (int i = 0; i < 3; i++) if (ack_w[g][i] && pend[g][i] > 0) begin
        pend[g][i]--;
        if (pend[g][i] == 0) req_s[g][i] = 1'b0;
      end
      ok = pend[g][0] + pend[g][1] + pend[g][2] == 0;
    end
    if (!ok) tmo++;
    repeat (3) @(negedge clk1);
  endtask

  initial begin
    int n;
    rst_s = 2'b11;
    for (int g = 0; g < 2; g++) begin
      req_s[g] = '0;
      we_s[g] = '0;
      addr_s[g] = '0;
      wdata_s[g] = '0;
      for (int i = 0; i < 3; i++) pend[g][i] = 0;
    end
    repeat (3) @(negedge clk1);
    pr(0, 1, GNT_NONE, 0, 0, 0, 1, 32'h0);
    pr(1, 1, GNT_NONE, 0, 0, 0, 1, 32'h0);
    @(negedge clk1);
    @(negedge clk1);
    rst_s = 2'b00;
    @(negedge clk1);
    // single fetch read, MEM_LAT=1
    set_rq(0, 2, 0, 10'd5, 32'h0, 1);
    n = cyc;
    ex(0, REQ_FETCH, 32'h1234ABCD, n + 3);
    pr(0, 1, REQ_FETCH, 1, 1, 10'd5, 0, 32'h0);
    pr(0, 2, REQ_FETCH, 1, 0, 10'd0, 0, 32'h0);
    pr(0, 3, REQ_FETCH, 1, 0, 10'd0, 1, 32'h1234ABCD);
    pr(0, 4, GNT_NONE, 0, 0, 10'd0, 1, 32'h1234ABCD);
    run(0);
    // data write beats fetch, fetch then reads the written word
    set_rq(0, 1, 1, 10'd7, 32'hDEADBEEF, 1);
    set_rq(0, 2, 0, 10'd7, 32'h0, 1);
    ex(0, REQ_DATA, 32'h1234ABCD, -1);
    ex(0, REQ_FETCH, 32'hDEADBEEF, -1);
    run(0);
    // starvation with STARVE_MAX=2, back-to-back every 4 cycles
    set_rq(0, 1, 0, 10'd20, 32'h0, 4);
    set_rq(0, 2, 0, 10'd5, 32'h0, 2);
    n = cyc;
    ex(0, REQ_DATA, 32'hC0DE0014, n + 3);
    ex(0, REQ_DATA, 32'hC0DE0014, n + 7);
    ex(0, REQ_FETCH, 32'h1234ABCD, n + 11);
    ex(0, REQ_DATA, 32'hC0DE0014, n + 15);
    ex(0, REQ_DATA, 32'hC0DE0014, n + 19);
    ex(0, REQ_FETCH, 32'h1234ABCD, n + 23);
    run(0);
    // loader wins twice; those losses starve fetch so it outranks data next
    set_rq(0, 0, 1, 10'd31, 32'h600DCAFE, 2);
    set_rq(0, 1, 0, 10'd31, 32'h0, 1);
    set_rq(0, 2, 0, 10'd7, 32'h0, 1);
    ex(0, REQ_LOAD, 32'h1234ABCD, -1);
    ex(0, REQ_LOAD, 32'h1234ABCD, -1);
    ex(0, REQ_FETCH, 32'hDEADBEEF, -1);
    ex(0, REQ_DATA, 32'h600DCAFE, -1);
    run(0);
    // fetch loses twice then withdraws; reset must clear the starve count
    for (int r = 0; r < 2; r++) begin
      set_rq(0, 1, 0, 10'd20, 32'h0, 1);
      set_rq(0, 2, 0, 10'd5, 32'h0, 0);
      ex(0, REQ_DATA, 32'hC0DE0014, -1);
      req_s[0] = 3'b110;
      @(negedge clk1);
      req_s[0][2] = 1'b0;
      run(0);
    end
    rst_s[0] = 1'b1;
    @(negedge clk1);
    rst_s[0] = 1'b0;
    @(negedge clk1);
    set_rq(0, 1, 0, 10'd20, 32'h0, 1);
    set_rq(0, 2, 0, 10'd5, 32'h0, 1);
    ex(0, REQ_DATA, 32'hC0DE0014, -1);
    ex(0, REQ_FETCH, 32'h1234ABCD, -1);
    run(0);
    // latency sweep, MEM_LAT=3
    set_rq(1, 2, 0, 10'd5, 32'h0, 1);
    n = cyc;
    ex(1, REQ_FETCH, 32'h1234ABCD, n + 5);
    pr(1, 1, REQ_FETCH, 1, 1, 10'd5, 0, 32'h0);
    pr(1, 2, REQ_FETCH, 1, 0, 10'd0, 0, 32'h0);
    pr(1, 3, REQ_FETCH, 1, 0, 10'd0, 0, 32'h0);
    pr(1, 4, REQ_FETCH, 1, 0, 10'd0, 1, 32'h0);
    pr(1, 5, REQ_FETCH, 1, 0, 10'd0, 1, 32'h1234ABCD);
    pr(1, 6, GNT_NONE, 0, 0, 10'd0, 1, 32'h1234ABCD);
    run(1);
    // loader priority with re-request while data and fetch wait
    set_rq(1, 0, 1, 10'd40, 32'h55AA55AA, 2);
    set_rq(1, 1, 0, 10'd40, 32'h0, 1);
    set_rq(1, 2, 0, 10'd41, 32'h0, 1);
    ex(1, REQ_LOAD, 32'h1234ABCD, -1);
    ex(1, REQ_LOAD, 32'h1234ABCD, -1);
    ex(1, REQ_DATA, 32'h55AA55AA, -1);
    ex(1, REQ_FETCH, 32'hC0DE0029, -1);
    run(1);
    // STARVE_MAX=4: fetch gets in after four data grants, period 6
    set_rq(1, 1, 0, 10'd50, 32'h0, 5);
    set_rq(1, 2, 0, 10'd5, 32'h0, 1);
    n = cyc;
    ex(1, REQ_DATA, 32'hC0DE0032, n + 5);
    ex(1, REQ_DATA, 32'hC0DE0032, n + 11);
    ex(1, REQ_DATA, 32'hC0DE0032, n + 17);
    ex(1, REQ_DATA, 32'hC0DE0032, n + 23);
    ex(1, REQ_FETCH, 32'h1234ABCD, n + 29);
    ex(1, REQ_DATA, 32'hC0DE0032, n + 35);
    run(1);
    // reset during WAIT: no ack, late mem_rdata discarded
    set_rq(1, 2, 0, 10'd9, 32'h0, 0);
    req_s[1] = 3'b100;
    pr(1, 1, REQ_FETCH, 1, 1, 10'd9, 1, 32'hC0DE0032);
    @(negedge clk1);
    @(negedge clk1);
    rst_s[1] = 1'b1;
    req_s[1] = 3'b000;
    pr(1, 1, GNT_NONE, 0, 0, 10'd0, 1, 32'h0);
    @(negedge clk1);
    rst_s[1] = 1'b0;
    repeat (8) @(negedge clk1);
    set_rq(1, 1, 0, 10'd9, 32'h0, 1);
    ex(1, REQ_DATA, 32'hC0DE0009, -1);
    run(1);
    done = 1'b1;
  end
endmodule

// File: doc/mips32_mem_arbiter.md
Name: mips32_mem_arbiter

Overview:
Shares the single 1024x32 word memory of the pipelined MIPS32 core between three requesters: the program loader, the MEM stage (LW/SW) and the IF stage (instruction fetch). It does fixed-priority arbitration with a starvation guard for fetch. It uses a req/ack handshake toward the requesters and drives a fixed-latency memory port. There is one outstanding access at a time, and it sits between the core pipeline and the memory array.

Parameters:
ADDR_W, 10, word-address width (1024 words)
MEM_LAT, 1, cycles from mem_en to valid mem_rdata; legal range 1..15
STARVE_MAX, 4, consecutive lost arbitrations after which fetch outranks the data port; legal range 1..15

Ports:
clk1  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req  in  3  request per requester; bit0=loader, bit1=data, bit2=fetch
we  in  3  per-requester write enable, valid while req high
addr  in  3*ADDR_W  per-requester word address; slice i belongs to requester i
wdata  in  96  per-requester write data; slice i is 32 bits
ack  out  3  one-cycle completion pulse per requester
rdata  out  32  read data, valid in the ack cycle, held until the next read completes
grant_id  out  2  index of the current owner; 3 means none
busy  out  1  high whenever state is not IDLE
mem_en  out  1  one-cycle memory strobe
mem_we  out  1  write qualifier, valid with mem_en
mem_addr  out  ADDR_W  memory address, valid with mem_en
mem_wdata  out  32  memory write data, valid with mem_en
mem_rdata  in  32  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Reset: state=IDLE, ack=0, rdata=0, grant_id=3, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, starve counter=0.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: at each edge, if any req bit is high, latch the winner's id, we, addr and wdata, then go to ISSUE. Otherwise stay in IDLE.
- Winner selection:
  - The loader always wins when it requests.
  - Otherwise data beats fetch, unless starve counter == STARVE_MAX; then fetch beats data.
- ISSUE: drive mem_en=1 with the latched mem_we/mem_addr/mem_wdata for exactly 1 cycle. Load the latency counter with MEM_LAT. Go to WAIT.
- WAIT: decrement the counter each cycle. When it reaches 0, capture mem_rdata into rdata (reads only; writes leave rdata unchanged) and go to RESP.
- RESP: ack[grant_id]=1 for 1 cycle, then go to IDLE and set grant_id=3.
  - The requester must drop req in the cycle after ack.
  - IDLE does not sample req in the RESP cycle, so a req still high in the cycle after ack is a new request.
- Latency: req first sampled at edge T gives an ack pulse in cycle T+MEM_LAT+2. Back-to-back requests are served every MEM_LAT+3 cycles.
- Starve counter:
  - Increments (saturating at STARVE_MAX) on each IDLE arbitration where fetch req=1 and fetch loses.
  - Clears to 0 when fetch is granted.
  - Unchanged otherwise.
- Request inputs are ignored while busy. The latched request is immune to req/addr changes after the IDLE sample.
- Addresses are word addresses; no truncation or wrap logic beyond ADDR_W bits.
- Reset mid-operation, in any state: return to IDLE at that edge. No ack is issued, mem_en is forced to 0, a later mem_rdata is discarded, and the starve counter clears.
- A request that drops before it is granted is simply never served; no error is raised.
- Exactly one ack bit may be high in any cycle. ack is never high while mem_en is high.

Decomposition:
- Package mips32_mem_pkg holds:
  - requester index constants REQ_LOAD=0, REQ_DATA=1, REQ_FETCH=2, GNT_NONE=3
  - state encoding IDLE/ISSUE/WAIT/RESP
  - the data width constant 32
- One sub-module, mips32_mem_prio_pick, is natural. It is combinational: it takes req[2:0] and starve_hit and returns the winner id plus a valid flag. The FSM, latency counter and starve counter stay in the top module.

Test Plan:
- Single fetch read: MEM_LAT=1, memory[5]=0x1234ABCD, req[2] at edge 0 with addr=5 -> mem_en in cycle 1 with mem_addr=5; ack[2] in cycle 3 with rdata=0x1234ABCD; grant_id=2 during cycles 1-3.
- Simultaneous data write and fetch: data we=1, addr=7, wdata=0xDEADBEEF; fetch read addr=7 -> data is served first (ack[1]); fetch is served next and returns 0xDEADBEEF.
- Starvation: STARVE_MAX=2, data and fetch both requesting continuously -> grant order data, data, fetch, data, data, fetch; the counter clears after each fetch grant.
- Loader priority: loader, data and fetch all request in the same cycle -> ack order loader, data, fetch; the loader wins again if it re-requests while the others are still pending.
- Latency sweep: MEM_LAT=3 -> ack arrives exactly 5 cycles after the req sample edge; busy stays high for 5 cycles.
- Reset in WAIT: rst is asserted 1 cycle after mem_en -> no ack pulse, grant_id=3 and busy=0 after the edge; the next request completes normally with correct data.
